sample_normalizer: RTL
======================

# sample_normalizer

Pipelined integer-to-float normalizer for the sample path. It accepts signed two's-complement samples over a valid/ready handshake and emits sign, exponent and a left-justified mantissa. The leading-one search is done by an instance of `high_bit_finder`. The block sits between the sample source and the float/gain stages, at one result per clock.

## Interface
- WIDTH, 24: sample width in bits; must be ≥ 4.
- EW, $clog2(WIDTH): exponent width (derived, not overridden).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  `in_data` is valid this cycle.
- in_ready  output  1  block accepts `in_data` this cycle.
- in_data  input  WIDTH  signed two's-complement sample.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sign  output  1  1 = negative sample.
- out_exponent  output  EW  bit position of the leading one of |sample|, range 0..WIDTH-1.
- out_mantissa  output  WIDTH  |sample| shifted left so that the MSB is 1.
- out_zero  output  1  sample was zero; mantissa and exponent are 0.

## Operation
- Transfer rule: a transfer occurs on a clock edge where valid && ready on the same side.
- Stage 1 (S1) captures each accepted input:
  - s1_sign = in_data[WIDTH-1].
  - s1_mag = |in_data| as WIDTH-bit unsigned.
  - The most negative input, -2^(WIDTH-1), gives magnitude 2^(WIDTH-1) with no overflow.
- Stage 2 (S2) takes shift = high_bit_finder(s1_mag) and registers:
  - out_mantissa = s1_mag << shift, truncated to WIDTH bits.
  - out_exponent = WIDTH-1-shift.
  - out_sign = s1_sign.
  - out_zero = (s1_mag == 0).
- Zero magnitude: `high_bit_finder` output is undefined for zero, so S2 must force out_mantissa=0, out_exponent=0, out_sign=0, out_zero=1.
- Pipeline flow control, one valid bit per stage:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready to in_ready, which is allowed.
- Register updates:
  - S2 loads S1's contents when s2_load. s2_valid then takes s1_valid.
  - S1 loads input when s1_load. s1_valid then takes in_valid && in_ready.
- Held state: a stage that does not load holds its data and valid unchanged.
- out_valid = s2_valid. Outputs must remain stable while out_valid && !out_ready.
- No drops or duplicates: every accepted sample produces exactly one result, in order.

## Timing
- Reset values: s1_valid, s2_valid = 0. out_valid=0, out_sign=0, out_exponent=0, out_mantissa=0, out_zero=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight samples. No result is emitted for them.
- Latency: a sample accepted at edge N shows out_valid=1 after edge N+1, i.e. it is available at edge N+2 with no stall.
- Throughput: one sample per clock while out_ready=1.
- Stall case: with both stages full and out_ready=0, in_ready=0.
- Simultaneous pop and push when full: out_ready=1 with both stages full gives in_ready=1 in the same cycle, and the pipeline advances without a bubble.
- Bubbles: an empty S1 must not block S2 from draining, and an empty S2 must not block S1 from advancing.
- No combinational path from in_data or in_valid to any output.

## Test plan
- Positive values, WIDTH=24, out_ready=1:
  - 24'h000001 -> sign 0, exp 0, mant 24'h800000, zero 0.
  - 24'h7FFFFF -> sign 0, exp 22, mant 24'hFFFFFE.
- Negative values:
  - 24'hFFFFFF -> sign 1, exp 0, mant 24'h800000.
  - 24'h800000 -> sign 1, exp 23, mant 24'h800000.
  - 24'hFFF000 -> sign 1, exp 12, mant 24'h800000.
- Zero: 24'h000000 -> zero 1, sign 0, exp 0, mant 0. The next sample, 24'h000003, -> exp 1, mant 24'hC00000.
- Streaming: 100 back-to-back random samples with out_ready=1. Required: in_ready stays 1, each result appears 2 cycles after its input, in order, and matches the model.
- Backpressure: random out_ready (about 50%) and random in_valid over 1000 samples. Required: no loss or duplication, outputs stable while stalled, in_ready=0 only when both stages are full and out_ready=0.
- Reset: reset asserted for 1 cycle with 2 samples in flight. Required: out_valid=0 on the next cycle and all outputs 0. The in-flight samples are never emitted. A new sample 24'h000010 then yields exp 4, mant 24'h800000 after 2 cycles.

Source files
------------

// File: rtl/sample_normalizer.sv
// Pipelined signed-integer to sign/exponent/mantissa normalizer with valid/ready flow control.
// Two register stages: S1 holds the magnitude, S2 holds the normalized result.

module high_bit_finder #(
  parameter int  WIDTH = 24,
  localparam int EW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [EW-1:0]    shift_o
);

  // Left shift that brings the highest set bit to the MSB; undefined (0) for a zero input.
  always_comb begin
    // NOTE: default first so every path assigns shift_o and no latch is inferred.
    shift_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value_i[i]) shift_o = EW'(WIDTH - 1 - i);
    end
  end

endmodule

module sample_normalizer #(
  parameter int  WIDTH = 24,
  localparam int EW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EW-1:0]    out_exponent,
  output logic [WIDTH-1:0] out_mantissa,
  output logic             out_zero
);

  typedef struct packed {
    logic             sign;
    logic [EW-1:0]    exponent;
    logic [WIDTH-1:0] mantissa;
    logic             zero;
  } result_t;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [WIDTH-1:0] s1_mag_q,   s1_mag_d;
  logic             s2_valid_q, s2_valid_d;
  result_t          s2_res_q,   s2_res_d;

  logic             s1_load;
  logic             s2_load;
  logic [EW-1:0]    shift;

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  high_bit_finder #(.WIDTH(WIDTH)) u_high_bit_finder (
    .value_i (s1_mag_q),
    .shift_o (shift)
  );

  // Two's-complement negate stays in WIDTH bits, so the most negative input
  // maps to 2^(WIDTH-1) as an unsigned magnitude.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in_data[WIDTH-1];
      s1_mag_d   = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_mag_q == '0) begin
        s2_res_d = '{sign: 1'b0, exponent: '0, mantissa: '0, zero: 1'b1};
      end else begin
        s2_res_d.sign     = s1_sign_q;
        s2_res_d.exponent = EW'(WIDTH - 1) - shift;
        s2_res_d.mantissa = s1_mag_q << shift;
        s2_res_d.zero     = 1'b0;
      end
    end
  end

  // Data registers are cleared with the valids so the outputs read all-zero after reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_sign     = s2_res_q.sign;
  assign out_exponent = s2_res_q.exponent;
  assign out_mantissa = s2_res_q.mantissa;
  assign out_zero     = s2_res_q.zero;

endmodule
